solver_work_dispatcher: RTL and testbench

//  Frame-level scheduler for the Mandelbrot solver array: walks a WIDTH x HEIGHT pixel raster,

---
 rtl/fractal_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/solver_work_dispatcher.sv | 165 ++++++++++++++++
 tb/tb_solver_work_dispatcher.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared widths and dispatcher state encoding for the Mandelbrot solver array.
package fractal_pkg;

  localparam int COORD_W     = 27;
  localparam int SOLVER_ID_W = 6;
  localparam int PIX_X_W     = 10;
  localparam int PIX_Y_W     = 9;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } disp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest-index request at or above ptr, wrapping to 0.
module rr_arbiter
  import fractal_pkg::*;
#(
  parameter int N = 29
) (
  input  logic [N-1:0]           req,
  input  logic [SOLVER_ID_W-1:0] ptr,
  output logic [N-1:0]           grant,
  output logic [SOLVER_ID_W-1:0] grant_id,
  output logic                   valid
);

  logic [N-1:0] upper;
  logic         found;

  assign valid = |req;

  // Search the at-or-above-pointer half first, then fall back to the whole vector
  always_comb begin
    grant    = '0;
    grant_id = '0;
    upper    = '0;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      upper[k] = req[k] && (k >= int'(ptr));
    end
    for (int k = 0; k < N; k++) begin
      if (!found && upper[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        grant_id = SOLVER_ID_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        grant_id = SOLVER_ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/solver_work_dispatcher.sv
// Frame scheduler: walks the pixel raster and hands one pixel per cycle to a requesting solver.
module solver_work_dispatcher
  import fractal_pkg::*;
#(
  parameter int NUM_SOLVERS = 29,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int COORD_W     = fractal_pkg::COORD_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] min_x,
  input  logic signed [COORD_W-1:0] min_y,
  input  logic signed [COORD_W-1:0] dx,
  input  logic signed [COORD_W-1:0] dy,
  input  logic [NUM_SOLVERS-1:0]    req,
  input  logic [NUM_SOLVERS-1:0]    busy,
  output logic [NUM_SOLVERS-1:0]    grant,
  output logic [SOLVER_ID_W-1:0]    grant_id,
  output logic [PIX_X_W-1:0]        pix_x,
  output logic [PIX_Y_W-1:0]        pix_y,
  output logic signed [COORD_W-1:0] c_re,
  output logic signed [COORD_W-1:0] c_im,
  output logic [31:0]               solve_time,
  output logic                      done
);

  disp_state_e state_q, state_d;
  logic        start_acc;

  logic [SOLVER_ID_W-1:0]    ptr_q;
  logic [NUM_SOLVERS-1:0]    grant_q;
  logic [NUM_SOLVERS-1:0]    elig;
  logic [NUM_SOLVERS-1:0]    arb_grant;
  logic [SOLVER_ID_W-1:0]    arb_id;
  logic                      arb_valid;

  logic [PIX_X_W-1:0]        x_q;
  logic [PIX_Y_W-1:0]        y_q;
  logic signed [COORD_W-1:0] cre_q, cim_q;
  logic signed [COORD_W-1:0] min_x_q, dx_q, dy_q;
  logic                      row_end, last_pix;

  assign row_end  = (x_q == PIX_X_W'(WIDTH - 1));
  assign last_pix = row_end && (y_q == PIX_Y_W'(HEIGHT - 1));

  // A solver granted last cycle is masked so it cannot be granted again before dropping req
  assign elig  = (state_q == StRun) ? (req & ~grant_q) : '0;
  assign grant = grant_q;

  rr_arbiter #(
    .N(NUM_SOLVERS)
  ) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .grant   (arb_grant),
    .grant_id(arb_id),
    .valid   (arb_valid)
  );

  // Next-state logic and start acceptance
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StRun;
          start_acc = 1'b1;
        end
      end
      StRun: begin
        if (arb_valid && last_pix) state_d = StDrain;
      end
      StDrain: begin
        // grant_q is the previous cycle's grant; no grant is ever issued in DRAIN itself
        if ((busy == '0) && (grant_q == '0)) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and round-robin pointer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (arb_valid) begin
        ptr_q <= (arb_id == SOLVER_ID_W'(NUM_SOLVERS - 1)) ? '0 : arb_id + SOLVER_ID_W'(1);
      end
    end
  end

  // Raster position and incremental coordinates of the next pixel to hand out
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      cre_q   <= '0;
      cim_q   <= '0;
      min_x_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else if (start_acc) begin
      x_q     <= '0;
      y_q     <= '0;
      cre_q   <= min_x;
      cim_q   <= min_y;
      min_x_q <= min_x;
      dx_q    <= dx;
      dy_q    <= dy;
    end else if (arb_valid) begin
      if (row_end) begin
        x_q   <= '0;
        cre_q <= min_x_q;
        y_q   <= y_q + PIX_Y_W'(1);
        cim_q <= cim_q + dy_q;
      end else begin
        x_q   <= x_q + PIX_X_W'(1);
        cre_q <= cre_q + dx_q;
      end
    end
  end

  // Registered grant bundle; payload holds its last value between grants
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q  <= '0;
      grant_id <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      c_re     <= '0;
      c_im     <= '0;
    end else begin
      grant_q <= arb_grant;
      if (arb_valid) begin
        grant_id <= arb_id;
        pix_x    <= x_q;
        pix_y    <= y_q;
        c_re     <= cre_q;
        c_im     <= cim_q;
      end
    end
  end

  // Saturating solve timer and frame-done flag
  always_ff @(posedge clock) begin
    if (reset) begin
      solve_time <= '0;
      done       <= 1'b0;
    end else if (start_acc) begin
      solve_time <= '0;
      done       <= 1'b0;
    end else begin
      if (((state_q == StRun) || (state_q == StDrain)) && (solve_time != '1)) begin
        solve_time <= solve_time + 32'd1;
      end
      if ((state_q == StDrain) && (state_d == StDone)) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_solver_work_dispatcher.sv
// Self-checking bench: directed scenarios plus random traffic against a pixel-index reference model.
module tb_solver_work_dispatcher;

  localparam int N  = 5;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 27;

  logic                 clock = 1'b0;
  logic                 reset, start;
  logic signed [CW-1:0] min_x, min_y, dx, dy;
  logic [N-1:0]         req, busy;
  logic [N-1:0]         grant;
  logic [5:0]           grant_id;
  logic [9:0]           pix_x;
  logic [8:0]           pix_y;
  logic signed [CW-1:0] c_re, c_im;
  logic [31:0]          solve_time;
  logic                 done;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done
  int           m_phase = 0;
  int           m_k     = 0;
  int           m_ptr   = 0;
  logic [N-1:0] m_grant = '0;
  logic [CW-1:0] m_minx, m_miny, m_dx, m_dy;
  longint       m_time  = 0;
  bit           m_done  = 1'b0;

  solver_work_dispatcher #(
    .NUM_SOLVERS(N),
    .WIDTH      (W),
    .HEIGHT     (H),
    .COORD_W    (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .min_x     (min_x),
    .min_y     (min_y),
    .dx        (dx),
    .dy        (dy),
    .req       (req),
    .busy      (busy),
    .grant     (grant),
    .grant_id  (grant_id),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .c_re      (c_re),
    .c_im      (c_im),
    .solve_time(solve_time),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] b, input bit s, input bit rs);
    logic [N-1:0]  elig;
    logic [N-1:0]  eg;
    logic [CW-1:0] ecre, ecim;
    int            gid, px, py;
    bit            found;
    req   = r;
    busy  = b;
    start = s;
    reset = rs;
    eg    = '0;
    found = 1'b0;
    gid   = 0;
    px    = 0;
    py    = 0;
    ecre  = '0;
    ecim  = '0;
    if (rs) begin
      m_phase = 0;
      m_ptr   = 0;
      m_grant = '0;
      m_time  = 0;
      m_done  = 1'b0;
    end else begin
      if (m_phase == 1) begin
        elig = r & ~m_grant;
        for (int o = 0; o < N; o++) begin
          int i;
          i = (m_ptr + o) % N;
          if (!found && elig[i]) begin
            found = 1'b1;
            gid   = i;
          end
        end
        if (found) begin
          eg[gid] = 1'b1;
          px      = m_k % W;
          py      = m_k / W;
          ecre    = m_minx + CW'(px) * m_dx;
          ecim    = m_miny + CW'(py) * m_dy;
          m_k++;
          m_ptr   = (gid + 1) % N;
        end
      end
      case (m_phase)
        0, 3: begin
          if (s) begin
            m_phase = 1;
            m_minx  = min_x;
            m_miny  = min_y;
            m_dx    = dx;
            m_dy    = dy;
            m_k     = 0;
            m_time  = 0;
            m_done  = 1'b0;
          end
        end
        1: begin
          m_time++;
          if (found && m_k == W * H) m_phase = 2;
        end
        default: begin
          m_time++;
          if (b == '0 && m_grant == '0) begin
            m_phase = 3;
            m_done  = 1'b1;
          end
        end
      endcase
      m_grant = eg;
    end
    @(posedge clock);
    #1;
    chk("grant", 64'(grant), 64'(eg));
    chk("done", 64'(done), 64'(m_done));
    chk("solve_time", 64'(solve_time), 64'(m_time));
    if (found) begin
      chk("grant_id", 64'(grant_id), 64'(gid));
      chk("pix_x", 64'(pix_x), 64'(px));
      chk("pix_y", 64'(pix_y), 64'(py));
      chk("c_re", 64'({c_re}), 64'(ecre));
      chk("c_im", 64'({c_im}), 64'(ecim));
    end
    if (rs) begin
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_pix_x", 64'(pix_x), 64'd0);
      chk("rst_pix_y", 64'(pix_y), 64'd0);
      chk("rst_c_re", 64'({c_re}), 64'd0);
      chk("rst_c_im", 64'({c_im}), 64'd0);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    req   = '0;
    busy  = '0;
    min_x = '0;
    min_y = '0;
    dx    = '0;
    dy    = '0;
    m_minx = '0;
    m_miny = '0;
    m_dx   = '0;
    m_dy   = '0;

    // Reset state
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b0);

    // Four solvers requesting constantly, -2.0 origin with 1/128 step (23 fraction bits)
    min_x = -27'sd16777216;
    min_y = 27'sd3145728;
    dx    = 27'sd65536;
    dy    = -27'sd32768;
    cycle('0, '0, 1'b1, 1'b0);
    min_x = 27'sd12345;  // must not disturb the running frame
    dx    = 27'sd7;
    for (int c = 0; c < 16; c++) cycle(5'b01111, '0, 1'b0, 1'b0);

    // Single solver: row wrap, twelve grants, then drain to done
    cycle('0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 30; c++) cycle(5'b00001, '0, 1'b0, 1'b0);

    // Pointer reaches 2, then both 0 and 1 request: wrap to 0, then 1
    cycle('0, '0, 1'b1, 1'b0);
    cycle(5'b00001, '0, 1'b0, 1'b0);
    cycle(5'b00010, '0, 1'b0, 1'b0);
    cycle(5'b00000, '0, 1'b0, 1'b0);
    cycle(5'b00011, '0, 1'b0, 1'b0);
    chk("wrap_grant", 64'(grant), 64'(5'b00001));
    cycle(5'b00011, '0, 1'b0, 1'b0);
    chk("no_double_grant", 64'(grant), 64'(5'b00010));
    for (int c = 0; c < 20; c++) cycle(5'b00001, '0, 1'b0, 1'b0);

    // Busy held after the last grant keeps done low; timer freezes once done
    cycle('0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 12; c++) cycle(5'b11111, 5'b11111, 1'b0, 1'b0);
    for (int c = 0; c < 50; c++) cycle('0, 5'b00100, 1'b0, 1'b0);
    chk("done_held_low", 64'(done), 64'd0);
    for (int c = 0; c < 3; c++) cycle('0, '0, 1'b0, 1'b0);
    chk("done_after_busy", 64'(done), 64'd1);
    for (int c = 0; c < 5; c++) cycle('0, '0, 1'b0, 1'b0);

    // Start mid-frame is ignored; reset mid-frame abandons it
    cycle('0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) cycle(5'b11111, '0, 1'b0, 1'b0);
    cycle(5'b11111, '0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) cycle(5'b11111, '0, 1'b0, 1'b0);
    cycle(5'b11111, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b1, 1'b0);
    cycle(5'b11111, '0, 1'b0, 1'b0);
    chk("restart_pix_x", 64'(pix_x), 64'd0);
    for (int c = 0; c < 20; c++) cycle(5'b11111, '0, 1'b0, 1'b0);

    // Coordinate wrap: most positive origin plus one wraps to most negative
    min_x = 27'sd67108863;
    dx    = 27'sd1;
    min_y = -27'sd67108864;
    dy    = -27'sd1;
    cycle('0, '0, 1'b1, 1'b0);
    cycle(5'b00001, '0, 1'b0, 1'b0);
    cycle(5'b00010, '0, 1'b0, 1'b0);
    chk("c_re_wrap", 64'({c_re}), 64'(27'h4000000));
    for (int c = 0; c < 20; c++) cycle(5'b11111, '0, 1'b0, 1'b0);

    // Random traffic across several frames
    for (int f = 0; f < 6; f++) begin
      min_x = CW'($urandom);
      min_y = CW'($urandom);
      dx    = CW'($urandom);
      dy    = CW'($urandom);
      cycle(N'($urandom), '0, 1'b1, 1'b0);
      for (int c = 0; c < 70; c++) begin
        logic [N-1:0] rb;
        rb    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
        min_x = CW'($urandom);
        cycle(N'($urandom), rb, ($urandom_range(0, 15) == 0), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
